// File: rtl/bra_issue_station_if.sv
// Dispatch, CDB, BRA and result channels of the BRA issue station.
// slave = station side, master = surrounding core side.
interface bra_issue_station_if #(
  parameter int unsigned ROB_W = 4
);
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_op;
  logic [31:0]      disp_vj;
  logic [31:0]      disp_vk;
  logic             disp_rj;
  logic             disp_rk;
  logic [ROB_W-1:0] disp_qj;
  logic [ROB_W-1:0] disp_qk;
  logic [31:0]      disp_pc;
  logic [31:0]      disp_off;
  logic [ROB_W-1:0] disp_dest;

  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  logic [3:0]       bra_op;
  logic [31:0]      bra_srca;
  logic [31:0]      bra_srcb;
  logic [31:0]      bra_pc;
  logic [31:0]      bra_off;
  logic [ROB_W-1:0] bra_dest;
  logic             bra_jump;
  logic [31:0]      bra_addr;
  logic [31:0]      bra_link;

  logic             res_valid;
  logic             res_ready;
  logic [ROB_W-1:0] res_tag;
  logic             res_jump;
  logic [31:0]      res_addr;
  logic [31:0]      res_link;
  logic             res_wb;

  modport slave (
    input  disp_valid, disp_op, disp_vj, disp_vk, disp_rj, disp_rk,
           disp_qj, disp_qk, disp_pc, disp_off, disp_dest,
    output disp_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    output bra_op, bra_srca, bra_srcb, bra_pc, bra_off, bra_dest,
    input  bra_jump, bra_addr, bra_link,
    output res_valid, res_tag, res_jump, res_addr, res_link, res_wb,
    input  res_ready
  );

  modport master (
    output disp_valid, disp_op, disp_vj, disp_vk, disp_rj, disp_rk,
           disp_qj, disp_qk, disp_pc, disp_off, disp_dest,
    input  disp_ready,
    output cdb_valid, cdb_tag, cdb_data,
    input  bra_op, bra_srca, bra_srcb, bra_pc, bra_off, bra_dest,
    output bra_jump, bra_addr, bra_link,
    input  res_valid, res_tag, res_jump, res_addr, res_link, res_wb,
    output res_ready
  );
endinterface

// File: rtl/bra_issue_station.sv
// Reservation station for the combinational BRA unit: captures operands off the CDB,
// issues the oldest ready op and holds the registered outcome until it is accepted.
module bra_issue_station #(
  parameter int unsigned RS_DEPTH = 4,
  parameter int unsigned ROB_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  bra_issue_station_if.slave bus
);
  localparam int unsigned IDX_W   = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam logic [3:0]  OP_NOP  = 4'd0;
  localparam logic [3:0]  OP_JAL  = 4'd1;
  localparam logic [3:0]  OP_JALR = 4'd2;

  logic [RS_DEPTH-1:0] valid;
  logic [RS_DEPTH-1:0] rj;
  logic [RS_DEPTH-1:0] rk;
  logic [3:0]          op   [RS_DEPTH];
  logic [31:0]         vj   [RS_DEPTH];
  logic [31:0]         vk   [RS_DEPTH];
  logic [ROB_W-1:0]    qj   [RS_DEPTH];
  logic [ROB_W-1:0]    qk   [RS_DEPTH];
  logic [31:0]         pc   [RS_DEPTH];
  logic [31:0]         off  [RS_DEPTH];
  logic [ROB_W-1:0]    dest [RS_DEPTH];
  // older[i][j] set means entry i was dispatched before entry j
  logic [RS_DEPTH-1:0] older [RS_DEPTH];

  logic                res_valid;
  logic [ROB_W-1:0]    res_tag;
  logic                res_jump;
  logic [31:0]         res_addr;
  logic [31:0]         res_link;
  logic                res_wb;

  logic [RS_DEPTH-1:0] ready_c;
  logic [RS_DEPTH-1:0] sel_oh_c;
  logic [IDX_W-1:0]    sel_idx_c;
  logic [IDX_W-1:0]    free_idx_c;
  logic                issue_ok_c;
  logic                issue_c;
  logic                free_any_c;
  logic                alloc_c;
  logic                disp_rj_c;
  logic                disp_rk_c;
  logic [31:0]         disp_vj_c;
  logic [31:0]         disp_vk_c;

  // Oldest-ready select, free-slot search and dispatch-time CDB bypass
  always_comb begin
    logic blocked;
    logic hit_j;
    logic hit_k;
    logic is_jal;
    logic is_jalr;
    blocked    = 1'b0;
    ready_c    = valid & rj & rk;
    issue_ok_c = !res_valid || bus.res_ready;
    sel_oh_c   = '0;
    sel_idx_c  = '0;
    free_idx_c = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (ready_c[j] && older[j][i]) blocked = 1'b1;
      end
      sel_oh_c[i] = ready_c[i] && !blocked && issue_ok_c;
      if (sel_oh_c[i]) sel_idx_c = IDX_W'(i);
    end
    issue_c = |sel_oh_c;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx_c = IDX_W'(i);
    end
    free_any_c = !(&valid);
    alloc_c    = bus.disp_valid && free_any_c && !flush && (bus.disp_op != OP_NOP);

    is_jal    = bus.disp_op == OP_JAL;
    is_jalr   = bus.disp_op == OP_JALR;
    hit_j     = !bus.disp_rj && bus.cdb_valid && (bus.disp_qj == bus.cdb_tag);
    hit_k     = !bus.disp_rk && bus.cdb_valid && (bus.disp_qk == bus.cdb_tag);
    disp_rj_c = bus.disp_rj || is_jal || hit_j;
    disp_rk_c = bus.disp_rk || is_jal || is_jalr || hit_k;
    disp_vj_c = hit_j ? bus.cdb_data : bus.disp_vj;
    disp_vk_c = hit_k ? bus.cdb_data : bus.disp_vk;
  end

  always_comb begin
    bus.disp_ready = free_any_c;
    bus.bra_op     = issue_c ? op[sel_idx_c] : OP_NOP;
    bus.bra_srca   = vj[sel_idx_c];
    bus.bra_srcb   = vk[sel_idx_c];
    bus.bra_pc     = pc[sel_idx_c];
    bus.bra_off    = off[sel_idx_c];
    bus.bra_dest   = dest[sel_idx_c];
    bus.res_valid  = res_valid;
    bus.res_tag    = res_tag;
    bus.res_jump   = res_jump;
    bus.res_addr   = res_addr;
    bus.res_link   = res_link;
    bus.res_wb     = res_wb;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid     <= '0;
      res_valid <= 1'b0;
      if (rst) begin
        res_tag  <= '0;
        res_jump <= 1'b0;
        res_addr <= '0;
        res_link <= '0;
        res_wb   <= 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
      end
    end else begin
      // Wakeup from the CDB
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid[i] && !rj[i] && bus.cdb_valid && (qj[i] == bus.cdb_tag)) begin
          vj[i] <= bus.cdb_data;
          rj[i] <= 1'b1;
        end
        if (valid[i] && !rk[i] && bus.cdb_valid && (qk[i] == bus.cdb_tag)) begin
          vk[i] <= bus.cdb_data;
          rk[i] <= 1'b1;
        end
      end

      if (issue_c) begin
        valid[sel_idx_c] <= 1'b0;
        res_valid        <= 1'b1;
        res_tag          <= dest[sel_idx_c];
        res_jump         <= bus.bra_jump;
        res_addr         <= bus.bra_addr;
        res_link         <= bus.bra_link;
        res_wb           <= (op[sel_idx_c] == OP_JAL) || (op[sel_idx_c] == OP_JALR);
      end else if (bus.res_ready) begin
        res_valid <= 1'b0;
      end

      if (alloc_c) begin
        valid[free_idx_c] <= 1'b1;
        op[free_idx_c]    <= bus.disp_op;
        vj[free_idx_c]    <= disp_vj_c;
        vk[free_idx_c]    <= disp_vk_c;
        rj[free_idx_c]    <= disp_rj_c;
        rk[free_idx_c]    <= disp_rk_c;
        qj[free_idx_c]    <= bus.disp_qj;
        qk[free_idx_c]    <= bus.disp_qk;
        pc[free_idx_c]    <= bus.disp_pc;
        off[free_idx_c]   <= bus.disp_off;
        dest[free_idx_c]  <= bus.disp_dest;
        for (int j = 0; j < RS_DEPTH; j++) begin
          older[j][free_idx_c] <= valid[j];
        end
        older[free_idx_c] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bra_issue_station.sv
// Self-checking bench for bra_issue_station: vector table plus multi-cycle scenarios,
// with a result scoreboard drained by a handshake monitor.
module tb_bra_issue_station;
  localparam logic [3:0] NOP = 4'd0, JAL = 4'd1, JALR = 4'd2, BEQ = 4'd3, BNE = 4'd4,
                         BLT = 4'd5, BGE = 4'd6, BLTU = 4'd7, BGEU = 4'd8;
  localparam int NV = 8;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] vj, vk, pc, off;
    logic [3:0]  dest;
    logic        jump;
    logic [31:0] addr, link;
    logic        wb;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic        jump;
    logic [31:0] addr, link;
    logic        wb;
  } res_t;

  logic clk = 1'b0;
  logic rst, flush;
  int   n_checks = 0;
  int   n_pass   = 0;
  res_t sb[$];
  vec_t vecs[NV];

  bra_issue_station_if #(.ROB_W(4)) bus ();

  bra_issue_station #(.RS_DEPTH(4), .ROB_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of the combinational BRA unit
  always_comb begin
    logic taken;
    taken        = 1'b0;
    bus.bra_link = bus.bra_pc + 32'd4;
    case (bus.bra_op)
      JAL, JALR: taken = 1'b1;
      BEQ:  taken = bus.bra_srca == bus.bra_srcb;
      BNE:  taken = bus.bra_srca != bus.bra_srcb;
      BLT:  taken = $signed(bus.bra_srca) <  $signed(bus.bra_srcb);
      BGE:  taken = $signed(bus.bra_srca) >= $signed(bus.bra_srcb);
      BLTU: taken = bus.bra_srca <  bus.bra_srcb;
      BGEU: taken = bus.bra_srca >= bus.bra_srcb;
      default: taken = 1'b0;
    endcase
    bus.bra_jump = taken;
    if (bus.bra_op == JALR)  bus.bra_addr = (bus.bra_srca + bus.bra_off) & ~32'd1;
    else if (taken)          bus.bra_addr = bus.bra_pc + bus.bra_off;
    else                     bus.bra_addr = bus.bra_pc + 32'd4;
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Scoreboard drain on every accepted result
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        check("res_unexpected", 64'(bus.res_tag), 64'hdead);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("res_tag",  64'(bus.res_tag),  64'(e.tag));
        check("res_jump", 64'(bus.res_jump), 64'(e.jump));
        check("res_addr", 64'(bus.res_addr), 64'(e.addr));
        check("res_link", 64'(bus.res_link), 64'(e.link));
        check("res_wb",   64'(bus.res_wb),   64'(e.wb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic rj, input logic rk, input logic [3:0] qj, input logic [3:0] qk,
                      input logic [31:0] pc, input logic [31:0] off, input logic [3:0] dest);
    bus.disp_valid = 1'b1;
    bus.disp_op    = op;
    bus.disp_vj    = vj;
    bus.disp_vk    = vk;
    bus.disp_rj    = rj;
    bus.disp_rk    = rk;
    bus.disp_qj    = qj;
    bus.disp_qk    = qk;
    bus.disp_pc    = pc;
    bus.disp_off   = off;
    bus.disp_dest  = dest;
  endtask

  task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid = v;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  function automatic res_t mk(input logic [3:0] tag, input logic jump, input logic [31:0] addr,
                              input logic [31:0] link, input logic wb);
    res_t r;
    r.tag = tag; r.jump = jump; r.addr = addr; r.link = link; r.wb = wb;
    return r;
  endfunction

  initial begin
    vecs[0] = '{BEQ,  32'd5,        32'd5, 32'h100, 32'h20,       4'd3, 1'b1, 32'h120,  32'h104, 1'b0};
    vecs[1] = '{BNE,  32'd5,        32'd5, 32'h100, 32'h20,       4'd4, 1'b0, 32'h104,  32'h104, 1'b0};
    vecs[2] = '{BLT,  32'hFFFFFFFF, 32'd1, 32'h300, 32'hFFFFFFF0, 4'd5, 1'b1, 32'h2F0,  32'h304, 1'b0};
    vecs[3] = '{BLTU, 32'hFFFFFFFF, 32'd1, 32'h300, 32'hFFFFFFF0, 4'd6, 1'b0, 32'h304,  32'h304, 1'b0};
    vecs[4] = '{JAL,  32'd0,        32'd0, 32'h400, 32'h100,      4'd7, 1'b1, 32'h500,  32'h404, 1'b1};
    vecs[5] = '{JALR, 32'h1001,     32'd0, 32'h500, 32'h2,        4'd8, 1'b1, 32'h1002, 32'h504, 1'b1};
    vecs[6] = '{BGE,  32'd3,        32'd3, 32'h10,  32'h8,        4'd9, 1'b1, 32'h18,   32'h14,  1'b0};
    vecs[7] = '{BGEU, 32'd1,        32'd2, 32'h10,  32'h8,        4'd10, 1'b0, 32'h14,  32'h14,  1'b0};

    // Reset with a dispatch request pending: nothing may be allocated
    rst = 1'b1; flush = 1'b0; bus.res_ready = 1'b1;
    cdb(1'b0, 4'd0, 32'd0);
    disp(BEQ, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'h40, 32'h4, 4'd1);
    tick(); tick();
    rst = 1'b0; bus.disp_valid = 1'b0;
    check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("rst_res_valid",  64'(bus.res_valid),  64'd0);
    check("rst_bra_op",     64'(bus.bra_op),     64'(NOP));
    tick();
    check("rst_no_alloc",   64'(bus.bra_op),     64'(NOP));
    check("rst_res_valid2", 64'(bus.res_valid),  64'd0);

    // Table: operands ready at dispatch -> issue at t+1, result at t+2
    for (int i = 0; i < NV; i++) begin
      disp(vecs[i].op, vecs[i].vj, vecs[i].vk, 1'b1, 1'b1, 4'd0, 4'd0,
           vecs[i].pc, vecs[i].off, vecs[i].dest);
      tick();
      bus.disp_valid = 1'b0;
      check($sformatf("vec%0d_bra_op", i),   64'(bus.bra_op),   64'(vecs[i].op));
      check($sformatf("vec%0d_bra_srca", i), 64'(bus.bra_srca), 64'(vecs[i].vj));
      check($sformatf("vec%0d_bra_dest", i), 64'(bus.bra_dest), 64'(vecs[i].dest));
      sb.push_back(mk(vecs[i].dest, vecs[i].jump, vecs[i].addr, vecs[i].link, vecs[i].wb));
      tick();
      check($sformatf("vec%0d_res_valid", i), 64'(bus.res_valid), 64'd1);
    end
    tick();

    // JALR waiting on tag 7; rk must be forced (qk tag never broadcast)
    disp(JALR, 32'd0, 32'd0, 1'b0, 1'b0, 4'd7, 4'd9, 32'h200, 32'h4, 4'd6);
    tick();
    bus.disp_valid = 1'b0;
    check("jalr_wait_t1", 64'(bus.bra_op), 64'(NOP));
    tick();
    check("jalr_wait_t2", 64'(bus.bra_op), 64'(NOP));
    tick();
    cdb(1'b1, 4'd7, 32'h1000);
    sb.push_back(mk(4'd6, 1'b1, 32'h1004, 32'h204, 1'b1));
    check("jalr_wait_t3", 64'(bus.bra_op), 64'(NOP));
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    check("jalr_issue_t4", 64'(bus.bra_op), 64'(JALR));
    tick();
    check("jalr_res_t5", 64'(bus.res_valid), 64'd1);
    tick();

    // Fill all entries with waiting ops, then wake entry 2 only
    for (int i = 0; i < 4; i++) begin
      disp(BEQ, 32'd0, 32'd0, 1'b0, 1'b1, 4'(8 + i), 4'd0, 32'h1000 + 32'(16 * i), 32'h40, 4'(8 + i));
      tick();
    end
    check("full_disp_ready", 64'(bus.disp_ready), 64'd0);
    check("full_no_issue",   64'(bus.bra_op),     64'(NOP));
    disp(BNE, 32'd1, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0, 32'h2000, 32'h10, 4'd12);
    cdb(1'b1, 4'd10, 32'd0);
    sb.push_back(mk(4'd10, 1'b1, 32'h1060, 32'h1024, 1'b0));
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    check("wake2_bra_op",     64'(bus.bra_op),     64'(BEQ));
    check("wake2_bra_dest",   64'(bus.bra_dest),   64'd10);
    check("wake2_disp_ready", 64'(bus.disp_ready), 64'd0);
    tick();
    check("freed_disp_ready", 64'(bus.disp_ready), 64'd1);
    sb.push_back(mk(4'd12, 1'b1, 32'h2010, 32'h2004, 1'b0));
    tick();
    bus.disp_valid = 1'b0;
    check("held_bra_dest", 64'(bus.bra_dest), 64'd12);
    cdb(1'b1, 4'd8, 32'd0);
    sb.push_back(mk(4'd8, 1'b1, 32'h1040, 32'h1004, 1'b0));
    tick();
    check("drain0_bra_dest", 64'(bus.bra_dest), 64'd8);
    cdb(1'b1, 4'd9, 32'd0);
    sb.push_back(mk(4'd9, 1'b1, 32'h1050, 32'h1014, 1'b0));
    tick();
    check("drain1_bra_dest", 64'(bus.bra_dest), 64'd9);
    cdb(1'b1, 4'd11, 32'd0);
    sb.push_back(mk(4'd11, 1'b1, 32'h1070, 32'h1034, 1'b0));
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    check("drain3_bra_dest", 64'(bus.bra_dest), 64'd11);
    tick(); tick();

    // Backpressure: X issues, Y wakes while the result is held
    bus.res_ready = 1'b0;
    disp(BEQ, 32'd7, 32'd8, 1'b1, 1'b1, 4'd0, 4'd0, 32'h600, 32'h30, 4'd1);
    sb.push_back(mk(4'd1, 1'b0, 32'h604, 32'h604, 1'b0));
    tick();
    disp(BLTU, 32'd0, 32'h10, 1'b0, 1'b1, 4'd13, 4'd0, 32'h700, 32'h80, 4'd2);
    sb.push_back(mk(4'd2, 1'b1, 32'h780, 32'h704, 1'b0));
    tick();
    bus.disp_valid = 1'b0;
    cdb(1'b1, 4'd13, 32'd5);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    check("bp_bra_op",    64'(bus.bra_op),    64'(NOP));
    check("bp_res_valid", 64'(bus.res_valid), 64'd1);
    check("bp_res_tag",   64'(bus.res_tag),   64'd1);
    check("bp_res_addr",  64'(bus.res_addr),  64'h604);
    tick();
    check("bp_hold_op",   64'(bus.bra_op),    64'(NOP));
    check("bp_hold_tag",  64'(bus.res_tag),   64'd1);
    check("bp_hold_addr", 64'(bus.res_addr),  64'h604);
    bus.res_ready = 1'b1;
    tick();
    check("bp_next_valid", 64'(bus.res_valid), 64'd1);
    check("bp_next_tag",   64'(bus.res_tag),   64'd2);
    tick(); tick();

    // Flush with 3 waiting entries, a held result, a dispatch and a CDB hit
    bus.res_ready = 1'b0;
    disp(BEQ, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'h800, 32'h8, 4'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      disp(BEQ, 32'd0, 32'd0, 1'b0, 1'b1, 4'd14, 4'd0, 32'h900, 32'h8, 4'(2 + i));
      tick();
    end
    check("fl_pre_res_valid", 64'(bus.res_valid), 64'd1);
    flush = 1'b1;
    disp(BEQ, 32'd2, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0, 32'hA00, 32'h8, 4'd5);
    cdb(1'b1, 4'd14, 32'd0);
    tick();
    flush = 1'b0;
    bus.disp_valid = 1'b0;
    cdb(1'b0, 4'd0, 32'd0);
    check("fl_res_valid",  64'(bus.res_valid),  64'd0);
    check("fl_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("fl_bra_op",     64'(bus.bra_op),     64'(NOP));
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fl_idle%0d_bra_op", i),    64'(bus.bra_op),    64'(NOP));
      check($sformatf("fl_idle%0d_res_valid", i), 64'(bus.res_valid), 64'd0);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
